// File: rtl/i2s_rx_capture_if.sv
// i2s_rx_capture_if: I2S pins plus the captured-sample stream between the receiver and its consumer.
interface i2s_rx_capture_if #(parameter int OUT_WIDTH = 16);
  logic i2s_clk;
  logic i2s_ws;
  logic i2s_sd;
  logic [OUT_WIDTH-1:0] sample_data;
  logic sample_valid;
  logic sample_ready;
  logic overrun;
  logic overrun_clr;
  modport master (
    output i2s_clk, i2s_ws, sample_data, sample_valid, overrun,
    input  i2s_sd, sample_ready, overrun_clr
  );
  modport slave (
    input  i2s_clk, i2s_ws, sample_data, sample_valid, overrun,
    output i2s_sd, sample_ready, overrun_clr
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: master-mode I2S receiver; generates SCK/WS, deserialises one slot, streams truncated PCM.
module i2s_rx_capture #(
  parameter int CLK_DIV   = 8,
  parameter int DATA_SIZE = 24,
  parameter int OUT_WIDTH = 16,
  parameter bit CHANNEL   = 1'b0
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  i2s_rx_capture_if.master bus
);
  localparam int CW = $clog2(CLK_DIV);
  logic sd_s1_q, sd_s2_q;
  logic [CW-1:0] div_q, div_d;
  logic sck_q, sck_d, ws_q, ws_d;
  logic [5:0] pos_q, pos_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic done_q, done_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, ovr_q, ovr_d;
  logic tick, rise, fall, slot;
  logic [4:0] b;
  always_comb begin
    tick    = en && div_q == CW'(CLK_DIV - 1);
    rise    = tick && !sck_q;
    fall    = tick && sck_q;
    b       = pos_q[4:0];
    slot    = rise && pos_q[5] == CHANNEL;
    div_d   = (!en || tick) ? '0 : div_q + 1'b1;
    sck_d   = en && (tick ? !sck_q : sck_q);
    pos_d   = !en ? '0 : fall ? pos_q + 6'd1 : pos_q;
    ws_d    = pos_d[5];
    // bit 0 of the slot is the I2S one-bit delay; bits past DATA_SIZE are tristated by the mic
    sh_d    = (!en || (slot && b == 5'd0)) ? '0
            : (slot && b <= 5'(DATA_SIZE)) ? {sh_q[DATA_SIZE-2:0], sd_s2_q} : sh_q;
    done_d  = slot && b == 5'(DATA_SIZE);
    data_d  = done_q ? sh_q[DATA_SIZE-1 -: OUT_WIDTH] : data_q;
    valid_d = done_q || (valid_q && !bus.sample_ready);
    ovr_d   = (done_q && valid_q && !bus.sample_ready) || (ovr_q && !bus.overrun_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_s1_q <= 1'b0;
      sd_s2_q <= 1'b0;
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      pos_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sd_s1_q <= bus.i2s_sd;
      sd_s2_q <= sd_s1_q;
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      pos_q   <= pos_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.i2s_clk      = sck_q;
  assign bus.i2s_ws       = ws_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = ovr_q;
endmodule
